fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_e     : fetch control state (StRun = normal fetch, StFlush = discarding stale responses)
//   DefXlen     : default address/PC width
//   DefDepth    : default prefetch buffer depth
//   DefResetPc  : default first fetch address
//   InstW       : instruction word width
package fetch_pkg;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  localparam int unsigned DefXlen    = 32;
  localparam int unsigned DefDepth   = 4;
  localparam logic [31:0] DefResetPc = 32'h0000_0000;
  localparam int unsigned InstW      = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, instruction} pairs.
//   clk, rst            : clock, asynchronous active-low reset
//   push, push_pc/data  : write an entry (ignored when full)
//   pop                 : drop the head entry (ignored when empty)
//   clear               : empty the buffer; wins over push and pop
//   full, empty, count  : occupancy status
//   head_pc, head_data  : head entry contents (meaningful only when not empty)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = DefXlen,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [InstW-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [XLEN-1:0]  head_pc,
  output logic [InstW-1:0] head_data
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [InstW-1:0] data_mem [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count   = wr_ptr_q - rd_ptr_q;
    do_push = push && !full && !clear;
    do_pop  = pop && !empty && !clear;
    head_pc   = pc_mem[rd_ptr_q[AW-1:0]];
    head_data = data_mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between a push and the matching pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr_q[AW-1:0]]   <= push_pc;
      data_mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a credit-limited prefetch buffer and redirect flushing.
//   clk, rst                         : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        : in-order fetch requests to instruction memory
//   imem_rsp_valid/data              : in-order instruction responses
//   redirect_valid/addr              : single-cycle branch/jump redirect to a new PC
//   inst_valid/ready/data/pc         : head of the prefetch buffer towards decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = DefXlen,
  parameter int unsigned     DEPTH    = DefDepth,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DefResetPc)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [InstW-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_addr,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [InstW-1:0] inst_data,
  output logic [XLEN-1:0]  inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic [CW-1:0]    disc_q, disc_d;
  logic [XLEN-1:0]  hold_pc_q;
  logic [InstW-1:0] hold_data_q;
  logic             err_q;

  logic             req_fire, rsp_take, credit_ok;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [XLEN-1:0]  head_pc;
  logic [InstW-1:0] head_data;

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_pc   (head_pc_unused_guard(pc_q)),
    .push_data (imem_rsp_data),
    .pop       (fifo_pop),
    .clear     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_data (head_data)
  );

  // PC of the oldest outstanding request: requests are issued to consecutive words,
  // so it is the fetch PC minus four per request still in flight.
  function automatic logic [XLEN-1:0] head_pc_unused_guard(input logic [XLEN-1:0] pc);
    return pc - {out_cnt_q, 2'b00};
  endfunction

  always_comb begin
    // Requests in flight plus buffered entries never exceed the buffer depth.
    credit_ok      = ({1'b0, out_cnt_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
    // Gated by rst so the request is low while reset is held.
    imem_req_valid = rst && (state_q == StRun) && credit_ok;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (out_cnt_q != '0);

    inst_valid = !fifo_empty;
    inst_data  = fifo_empty ? hold_data_q : head_data;
    inst_pc    = fifo_empty ? hold_pc_q : head_pc;

    fifo_push = (state_q == StRun) && rsp_take && !redirect_valid && !fifo_full;
    fifo_pop  = inst_valid && inst_ready;

    out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(rsp_take);

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_addr & ~XLEN'(3);
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end

    state_d = state_q;
    disc_d  = disc_q;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          // Everything still in flight after this edge is stale.
          disc_d  = out_cnt_d;
          state_d = (out_cnt_d != '0) ? StFlush : StRun;
        end
      end
      StFlush: begin
        disc_d = disc_q - CW'(rsp_take);
        if (disc_d == '0) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      out_cnt_q   <= '0;
      disc_q      <= '0;
      hold_pc_q   <= '0;
      hold_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_cnt_q <= out_cnt_d;
      disc_q    <= disc_d;
      // Remember the presented head so outputs hold while the buffer is empty.
      if (!fifo_empty) begin
        hold_pc_q   <= head_pc;
        hold_data_q <= head_data;
      end
      if (imem_rsp_valid && (out_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst) !err_q);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          hs0;
  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_pc, last_data;
  logic        rsp_hold;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (RstPc)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory model: answers each accepted request one cycle later unless held.
  always @(negedge clk) begin
    if (!rsp_hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Stimulus side of the scoreboard: checks each issued address and queues its expected delivery.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_pc);
        hs_count++;
        mem_q.push_back(imem_req_addr);
        if (!redirect_valid) exp_q.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = redirect_addr & 32'hFFFF_FFFC;
      end
    end
  end

  // Monitor: compares every delivered instruction against the scoreboard head.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #3;
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc 0x%08h, none expected", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_data", inst_data, e.data);
        last_pc   = e.pc;
        last_data = e.data;
      end
    end
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    rsp_hold       = 1'b0;
    exp_pc         = RstPc;
    last_pc        = 32'h0;
    last_data      = 32'h0;

    // Reset values
    step(2);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RstPc);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Streaming from RESET_PC with wrap-around; first request right after release
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    hs0 = hs_count;
    step(12);
    check("back_to_back", 32'(hs_count - hs0), 32'd12);
    imem_req_ready = 1'b0;
    step(4);
    check("empty_inst_valid", 32'(inst_valid), 32'd0);
    check("hold_inst_pc", inst_pc, last_pc);
    check("hold_inst_data", inst_data, last_data);
    check("drained_a", 32'(exp_q.size()), 32'd0);

    // Credit limit with decode stalled
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    hs0 = hs_count;
    step(10);
    check("credit_count", 32'(hs_count - hs0), 32'd4);
    check("credit_req_low", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    step(6);
    check("credit_after_pop", 32'(hs_count - hs0), 32'd5);
    check("credit_req_low2", 32'(imem_req_valid), 32'd0);
    inst_ready     = 1'b1;
    imem_req_ready = 1'b0;
    step(8);
    check("drained_b", 32'(exp_q.size()), 32'd0);

    // Redirect with two requests outstanding
    rsp_hold       = 1'b1;
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0103;
    step(1);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    hs0 = hs_count;
    step(3);
    check("flush_no_req", 32'(hs_count - hs0), 32'd0);
    check("flush_req_low", 32'(imem_req_valid), 32'd0);
    rsp_hold = 1'b0;
    step(6);
    imem_req_ready = 1'b0;
    step(6);
    check("redirect_first_pc_seen", 32'(hs_count - hs0 > 0), 32'd1);
    check("drained_c", 32'(exp_q.size()), 32'd0);

    // Stalled request stays stable, then is replaced by a redirect
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check("stall_req_addr", imem_req_addr, exp_pc);
    end
    redirect_valid = 1'b1;
    redirect_addr  = 32'h2000_0046;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h2000_0044);
    imem_req_ready = 1'b1;
    step(3);
    imem_req_ready = 1'b0;
    step(5);
    check("drained_d", 32'(exp_q.size()), 32'd0);

    // Reset with buffered entries and requests in flight
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0;
    step(3);
    rsp_hold       = 1'b1;
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0;
    step(1);
    check("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
    #1;
    rst = 1'b0;
    mem_q.delete();
    exp_q.delete();
    rsp_hold = 1'b0;
    exp_pc   = RstPc;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_req_addr", imem_req_addr, RstPc);
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst_data", inst_data, 32'h0);
    check("mid_rst_inst_pc", inst_pc, 32'h0);
    step(2);
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    #1;
    check("restart_req_addr", imem_req_addr, RstPc);
    step(4);
    imem_req_ready = 1'b0;
    step(4);
    check("drained_e", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
